// File: rtl/seq_divider.sv
// Signed radix-2 restoring divider: one quotient bit per clock, truncating toward zero.
// Undoes a prior shift-add multiply by a signed sine-table value on the normalisation path.
module seq_divider #(
    parameter int DW = 40,
    parameter int NS = 14
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic signed [DW-1:0] dividend,
    input  logic signed [NS-1:0] divisor,
    output logic signed [DW-1:0] quotient,
    output logic signed [NS-1:0] remainder,
    output logic                 busy,
    output logic                 done,
    output logic                 div_zero
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [CW-1:0] LAST = CW'(DW - 1);

    logic [1:0]    state;
    logic          sd;
    logic          sv;
    logic          dz;
    logic [CW-1:0] cnt;
    // q_sh starts as |dividend| and is shifted out MSB-first while quotient bits enter at the LSB
    logic [DW-1:0] q_sh;
    logic [NS-1:0] dvs_mag;
    logic [NS:0]   prem;
    logic [NS:0]   shifted;
    logic [NS+1:0] trial;

    function automatic logic [DW-1:0] mag_dw(input logic [DW-1:0] v);
        return v[DW-1] ? (~v + DW'(1)) : v;
    endfunction

    // |divisor| of -2^(NS-1) lands in the top bit, which acts as the guard bit
    function automatic logic [NS-1:0] mag_ns(input logic [NS-1:0] v);
        return v[NS-1] ? (~v + NS'(1)) : v;
    endfunction

    function automatic logic [DW-1:0] sat_quot(input logic neg);
        return neg ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    endfunction

    always_comb begin
        shifted = {prem[NS-1:0], q_sh[DW-1]};
        trial   = {1'b0, shifted} - {2'b00, dvs_mag};
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sd        <= 1'b0;
            sv        <= 1'b0;
            dz        <= 1'b0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sd      <= dividend[DW-1];
                        sv      <= divisor[NS-1];
                        dz      <= (divisor == '0);
                        q_sh    <= mag_dw(dividend);
                        dvs_mag <= mag_ns(divisor);
                        prem    <= '0;
                        cnt     <= '0;
                        state   <= CALC;
                    end
                end
                CALC: begin
                    // A zero divisor skips the iterations and spends one slot here, so done lands two edges after start
                    if (dz) begin
                        state <= FIX;
                    end else begin
                        q_sh <= {q_sh[DW-2:0], ~trial[NS+1]};
                        prem <= trial[NS+1] ? shifted : trial[NS:0];
                        cnt  <= cnt + 1'b1;
                        if (cnt == LAST) state <= FIX;
                    end
                end
                FIX: begin
                    done     <= 1'b1;
                    div_zero <= dz;
                    state    <= IDLE;
                    if (dz) begin
                        quotient  <= sat_quot(sd);
                        remainder <= '0;
                    end else begin
                        quotient  <= (sd ^ sv) ? -q_sh : q_sh;
                        remainder <= sd ? -prem[NS-1:0] : prem[NS-1:0];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: expected results are queued when an operation is
// accepted and compared by a monitor when done pulses; tasks check timing and handshake.
module tb_seq_divider;

    localparam int DW = 40;
    localparam int NS = 14;

    typedef struct {
        logic [DW-1:0] q;
        logic [NS-1:0] r;
        logic          dz;
    } exp_t;

    logic                 clk;
    logic                 rst;
    logic                 start;
    logic signed [DW-1:0] dividend;
    logic signed [NS-1:0] divisor;
    logic signed [DW-1:0] quotient;
    logic signed [NS-1:0] remainder;
    logic                 busy;
    logic                 done;
    logic                 div_zero;

    int     checks   = 0;
    int     failures = 0;
    longint cyc      = 0;
    exp_t   sb[$];

    seq_divider #(.DW(DW), .NS(NS)) dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .quotient(quotient), .remainder(remainder), .busy(busy), .done(done),
        .div_zero(div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input longint a, input longint b);
        exp_t        e;
        logic [63:0] t;
        logic [63:0] u;
        if (b == 0) begin
            t = 64'd1 << (DW - 1);
            if (a >= 0) t = t - 64'd1;
            e.q  = t[DW-1:0];
            e.r  = '0;
            e.dz = 1'b1;
        end else begin
            t = 64'(a / b);
            u = 64'(a % b);
            e.q  = t[DW-1:0];
            e.r  = u[NS-1:0];
            e.dz = 1'b0;
        end
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (done) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_done: done=1 at cycle %0d, required no result pending", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (quotient !== e.q) begin
                    failures++;
                    $display("FAIL quotient: got %h, required %h", quotient, e.q);
                end
                checks++;
                if (remainder !== e.r) begin
                    failures++;
                    $display("FAIL remainder: got %h, required %h", remainder, e.r);
                end
                checks++;
                if (div_zero !== e.dz) begin
                    failures++;
                    $display("FAIL div_zero: got %b, required %b", div_zero, e.dz);
                end
                checks++;
                if (busy !== 1'b0) begin
                    failures++;
                    $display("FAIL busy_at_done: got %b, required 0", busy);
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout: busy=%b, required 0", busy);
        end
    endtask

    // Launch one operation from an idle negedge and check the cycle the result appears.
    task automatic run_op(input longint a, input longint b, input int exp_lat, input string name);
        longint k;
        int     n = 0;
        logic [63:0] t;
        logic [63:0] u;
        wait_idle();
        t = 64'(a);
        u = 64'(b);
        dividend = t[DW-1:0];
        divisor  = u[NS-1:0];
        start    = 1'b1;
        sb.push_back(model(a, b));
        k = cyc + 1;
        @(negedge clk);
        start    = 1'b0;
        dividend = 40'h55_AAAA_5555;
        divisor  = 14'h1555;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL %s_timeout: done never seen, required at latency %0d", name, exp_lat);
            sb.delete();
        end else if (cyc - k != longint'(exp_lat)) begin
            failures++;
            $display("FAIL %s_latency: got %0d edges, required %0d", name, cyc - k, exp_lat);
        end
    endtask

    task automatic drain();
        int n = 0;
        start = 1'b0;
        while ((sb.size() != 0 || busy) && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0 || busy) begin
            failures++;
            $display("FAIL drain: %0d results outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic check_cleared(input string name);
        checks++;
        if (quotient !== '0 || remainder !== '0 || busy !== 1'b0 || done !== 1'b0 || div_zero !== 1'b0) begin
            failures++;
            $display("FAIL %s: q=%h r=%h busy=%b done=%b dz=%b, required all 0",
                     name, quotient, remainder, busy, done, div_zero);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        dividend = '0;
        divisor = '0;
        repeat (3) @(negedge clk);
        check_cleared("reset_state");
        rst = 1'b0;
    endtask

    task automatic test_basic();
        run_op(100, 7, DW + 1, "basic_100_7");
    endtask

    task automatic test_signs();
        run_op(-100, 7, DW + 1, "sign_nn_p");
        run_op(100, -7, DW + 1, "sign_p_n");
        run_op(-100, -7, DW + 1, "sign_n_n");
        run_op(6, -8192, DW + 1, "min_divisor");
        run_op(-8191, -8192, DW + 1, "min_divisor_rem");
    endtask

    task automatic test_extremes();
        run_op(-(longint'(1) <<< (DW - 1)), -1, DW + 1, "overflow_wrap");
        run_op((longint'(1) <<< (DW - 1)) - 1, 8191, DW + 1, "max_div_max");
        run_op(-(longint'(1) <<< (DW - 1)), 3, DW + 1, "min_div_3");
    endtask

    task automatic test_div_zero();
        run_op(5, 0, 2, "dz_pos");
        run_op(-5, 0, 2, "dz_neg");
        run_op(9, 3, DW + 1, "dz_clear");
    endtask

    // A start pulse mid-CALC must neither re-latch operands nor produce an extra result.
    task automatic test_start_ignored();
        longint k;
        int     n = 0;
        wait_idle();
        dividend = 40'sd1000;
        divisor  = 14'sd9;
        start    = 1'b1;
        sb.push_back(model(1000, 9));
        k = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        dividend = 40'sd777;
        divisor  = -14'sd5;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!done || cyc - k != longint'(DW + 1)) begin
            failures++;
            $display("FAIL ignored_start_latency: got %0d edges, required %0d", cyc - k, DW + 1);
        end
        repeat (DW + 5) @(negedge clk);
    endtask

    // start held high with fresh operands every cycle: only busy=0 cycles are accepted.
    task automatic test_back_to_back();
        longint last = -1;
        int     pulses = 0;
        logic [63:0] t;
        longint a;
        longint b;
        wait_idle();
        for (int i = 0; i < 4 * (DW + 2) + 3; i++) begin
            if (i > 0) begin
                if (done) begin
                    pulses++;
                    if (last >= 0) begin
                        checks++;
                        if (cyc - last != longint'(DW + 2)) begin
                            failures++;
                            $display("FAIL b2b_spacing: got %0d edges, required %0d", cyc - last, DW + 2);
                        end
                    end
                    last = cyc;
                end
            end
            t = {$urandom(), $urandom()};
            a = longint'($signed(t)) >>> (64 - DW);
            b = longint'($signed($urandom())) >>> (32 - NS);
            if (b == 0) b = 1;
            t = 64'(a);
            dividend = t[DW-1:0];
            t = 64'(b);
            divisor = t[NS-1:0];
            start = 1'b1;
            if (!busy) sb.push_back(model(a, b));
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (pulses < 3) begin
            failures++;
            $display("FAIL b2b_count: got %0d results, required at least 3", pulses);
        end
        drain();
    endtask

    task automatic test_mid_reset();
        exp_t dropped;
        run_op(-100, 7, DW + 1, "pre_reset");
        dividend = 40'sd12345;
        divisor  = 14'sd11;
        start    = 1'b1;
        sb.push_back(model(12345, 11));
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        dropped = sb.pop_back();
        @(negedge clk);
        check_cleared("mid_reset_clear");
        @(negedge clk);
        check_cleared("reset_over_start");
        rst   = 1'b0;
        start = 1'b0;
        repeat (DW + 5) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_discard_busy: got %b, required 0", busy);
        end
        run_op(12345, 11, DW + 1, "post_reset");
        run_op(-7, 100, DW + 1, "post_reset_small");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_extremes();
        test_div_zero();
        test_start_ignored();
        test_back_to_back();
        test_mid_reset();
        drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule
